// File: rtl/fsm_state_tracker_if.sv
// fsm_state_tracker_if: lap/error event stream, {kind[1:0], ts} under valid/ready
interface fsm_state_tracker_if #(parameter int TS_W = 12);
    logic            evt_valid;
    logic            evt_ready;
    logic [TS_W+1:0] evt_data;
    modport master (output evt_valid, evt_data, input evt_ready);
    modport slave  (input evt_valid, evt_data, output evt_ready);
endinterface

// File: rtl/fsm_state_tracker.sv
// fsm_state_tracker: ring-FSM step checker with position/lap counters and a timestamped event FIFO
// Define FSM_STATE_TRACKER_ERR_EVT_EN to also queue kind-11 events on illegal transitions.
package my_package_pkg;
    typedef enum logic [2:0] {
        FSM_ST0, FSM_ST1, FSM_ST2, FSM_ST3, FSM_ST4, FSM_ST5, FSM_ST6, FSM_ST7
    } FSM_States_t;
endpackage

module fsm_state_tracker #(
    parameter int POS_W = 16,
    parameter int LAP_W = 8,
    parameter int TS_W  = 12,
    parameter int DEPTH = 4
) (
    input  logic                        c,
    input  logic                        rst,
    input  my_package_pkg::FSM_States_t state_in,
    output logic signed [POS_W-1:0]     position,
    output logic signed [LAP_W-1:0]     laps,
    output logic                        err,
    output logic [7:0]                  err_cnt,
    fsm_state_tracker_if.master         evt,
    output logic                        ovf
);
    localparam int AW = $clog2(DEPTH);
    logic [TS_W-1:0] ts;
    logic [2:0]      prev_q, delta;
    logic            primed, fwd, bwd, ill, lap_f, lap_b, push, pop, full, wr;
    logic [1:0]      kind;
    logic [AW:0]     wp, rp;
    logic [TS_W+1:0] mem [DEPTH];

    always_comb begin
        delta = state_in - prev_q;
        fwd   = primed && delta == 3'd1;
        bwd   = primed && delta == 3'd7;
        ill   = primed && !fwd && !bwd;
        lap_f = fwd && prev_q == 3'd7;
        lap_b = bwd && prev_q == 3'd0;
`ifdef FSM_STATE_TRACKER_ERR_EVT_EN
        push  = lap_f || lap_b || ill;
        kind  = ill ? 2'b11 : lap_f ? 2'b01 : 2'b10;
`else
        push  = lap_f || lap_b;
        kind  = lap_f ? 2'b01 : 2'b10;
`endif
        full  = (wp - rp) == (AW+1)'(DEPTH);
        pop   = evt.evt_valid && evt.evt_ready;
        // a pop in the same cycle frees the slot a full-FIFO push needs
        wr    = push && (!full || pop);
    end

    assign evt.evt_valid = wp != rp;
    assign evt.evt_data  = mem[rp[AW-1:0]];

    always_ff @(posedge c) begin
        if (rst) begin
            ts       <= '0;
            prev_q   <= '0;
            primed   <= 1'b0;
            position <= '0;
            laps     <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
            ovf      <= 1'b0;
            wp       <= '0;
            rp       <= '0;
        end else begin
            ts     <= ts + TS_W'(1);
            prev_q <= state_in;
            primed <= 1'b1;
            if (fwd) position <= position + POS_W'(1);
            if (bwd) position <= position - POS_W'(1);
            if (lap_f) laps <= laps + LAP_W'(1);
            if (lap_b) laps <= laps - LAP_W'(1);
            if (ill) err <= 1'b1;
            if (ill && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
            if (wr) wp <= wp + (AW+1)'(1);
            if (pop) rp <= rp + (AW+1)'(1);
            if (push && !wr) ovf <= 1'b1;
        end
    end

    always_ff @(posedge c) begin
        if (!rst && wr) mem[wp[AW-1:0]] <= {kind, ts};
    end
endmodule
